pll_rst_seq: RTL and testbench

Reset sequencer and lock supervisor for the system PLL. It holds the PLL in reset at power-up and waits for a filtered lock. It then releases the per-domain resets (compute, system, VGA-side slow domain) one after another in a fixed order, and restarts the whole sequence on lock loss, lock timeout or a software request. It runs on the board reference clock, upstream of all PLL-derived logic; each `sys_rst` bit is re-synchronised by its consuming domain.

---
 rtl/pll_rst_seq.sv | 222 ++++++++++++++++++++++
 tb/tb_pll_rst_seq.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pll_rst_seq.sv
// pll_rst_seq: PLL reset sequencer and lock supervisor on the reference clock.
// Optional lock timeout built only when PLL_RST_SEQ_TIMEOUT_EN is defined.
module pll_rst_seq #(
   parameter int unsigned PLL_RST_CYCLES = 16,
   parameter int unsigned LOCK_FILT      = 256,
   parameter int unsigned LOCK_TIMEOUT   = 65536,
   parameter int unsigned RELEASE_GAP    = 8,
   parameter int unsigned NUM_RST        = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               pll_locked,
   input  logic               soft_rst,
   output logic               pll_rst,
   output logic [NUM_RST-1:0] sys_rst,
   output logic               ready,
   output logic [7:0]         retry_cnt
);

   function automatic int unsigned max3(
      input int unsigned a,
      input int unsigned b,
      input int unsigned c
   );
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

   localparam int unsigned REL_CYCLES = NUM_RST * RELEASE_GAP;
   localparam int unsigned CNT_MAX =
      max3(PLL_RST_CYCLES, LOCK_FILT, REL_CYCLES);
   localparam int unsigned CW = $clog2(CNT_MAX + 1);

   localparam logic [CW-1:0] PLL_LAST  = CW'(PLL_RST_CYCLES - 1);
   localparam logic [CW-1:0] FILT_LAST = CW'(LOCK_FILT - 1);
   localparam logic [CW-1:0] REL_LAST  = CW'(REL_CYCLES);

   if (PLL_RST_CYCLES < 1 || LOCK_FILT < 1 || RELEASE_GAP < 1 ||
       NUM_RST < 1 || NUM_RST > 8 || LOCK_TIMEOUT < 1) begin : g_bad_param
      $error("pll_rst_seq: parameter out of range");
   end

   typedef enum logic [2:0] {
      ST_RESET_PLL,
      ST_WAIT_LOCK,
      ST_FILTER,
      ST_RELEASE,
      ST_RUN
   } state_e;

   state_e             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               pll_rst_q, pll_rst_d;
   logic [NUM_RST-1:0] sys_rst_q, sys_rst_d;
   logic               ready_q, ready_d;
   logic [7:0]         retry_q, retry_d;
   logic               lock_meta_q, locked_s_q;
   logic               locked_s;
   logic               lock_lost;
   logic               timeout;

   assign locked_s = locked_s_q;

   // Two-flop synchroniser for the asynchronous PLL lock
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_meta_q <= 1'b0;
         locked_s_q  <= 1'b0;
      end else begin
         lock_meta_q <= pll_locked;
         locked_s_q  <= lock_meta_q;
      end
   end

`ifdef PLL_RST_SEQ_TIMEOUT_EN
   localparam int unsigned TW = $clog2(LOCK_TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(LOCK_TIMEOUT - 1);

   logic [TW-1:0] tmo_q, tmo_d;

   // Timeout fires on the cycle the lock window would be used up
   always_comb begin
      timeout = 1'b0;
      if (state_q == ST_WAIT_LOCK || state_q == ST_FILTER)
         timeout = (tmo_q == TMO_LAST);
   end

   // Window counts only while staying in WAIT_LOCK/FILTER
   always_comb begin
      tmo_d = '0;
      if ((state_q == ST_WAIT_LOCK || state_q == ST_FILTER) &&
          (state_d == ST_WAIT_LOCK || state_d == ST_FILTER))
         tmo_d = tmo_q + 1'b1;
   end

   // Timeout counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) tmo_q <= '0;
      else        tmo_q <= tmo_d;
   end
`else
   assign timeout = 1'b0;
`endif

   assign lock_lost = !locked_s &&
                      (state_q == ST_RELEASE || state_q == ST_RUN);

   // Next-state and registered-output logic, restart overrides last
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pll_rst_d = pll_rst_q;
      sys_rst_d = sys_rst_q;
      ready_d   = ready_q;
      retry_d   = retry_q;

      unique case (state_q)
         ST_RESET_PLL: begin
            pll_rst_d = 1'b1;
            if (cnt_q == PLL_LAST) begin
               state_d   = ST_WAIT_LOCK;
               cnt_d     = '0;
               pll_rst_d = 1'b0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_WAIT_LOCK: begin
            if (locked_s) begin
               state_d = ST_FILTER;
               cnt_d   = '0;
            end
         end
         ST_FILTER: begin
            if (!locked_s) begin
               state_d = ST_WAIT_LOCK;
               cnt_d   = '0;
            end else if (cnt_q == FILT_LAST) begin
               state_d = ST_RELEASE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_RELEASE: begin
            cnt_d = cnt_q + 1'b1;
            for (int unsigned k = 0; k < NUM_RST; k++) begin
               if (cnt_q >= CW'(k * RELEASE_GAP))
                  sys_rst_d[k] = 1'b0;
            end
            if (cnt_q == REL_LAST) begin
               state_d   = ST_RUN;
               cnt_d     = '0;
               sys_rst_d = '0;
               ready_d   = 1'b1;
            end
         end
         ST_RUN: begin
            cnt_d = '0;
         end
         default: begin
            state_d   = ST_RESET_PLL;
            cnt_d     = '0;
            pll_rst_d = 1'b1;
            sys_rst_d = '1;
            ready_d   = 1'b0;
         end
      endcase

      if (soft_rst || lock_lost || timeout) begin
         state_d   = ST_RESET_PLL;
         cnt_d     = '0;
         pll_rst_d = 1'b1;
         sys_rst_d = '1;
         ready_d   = 1'b0;
         if (!soft_rst && retry_q != 8'hFF)
            retry_d = retry_q + 8'd1;
      end
   end

   // State, counter and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_RESET_PLL;
         cnt_q     <= '0;
         pll_rst_q <= 1'b1;
         sys_rst_q <= '1;
         ready_q   <= 1'b0;
         retry_q   <= 8'd0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pll_rst_q <= pll_rst_d;
         sys_rst_q <= sys_rst_d;
         ready_q   <= ready_d;
         retry_q   <= retry_d;
      end
   end

   assign pll_rst   = pll_rst_q;
   assign sys_rst   = sys_rst_q;
   assign ready     = ready_q;
   assign retry_cnt = retry_q;

   a_pll_rst_held: assert property (
      @(posedge clk) disable iff (!rst_n)
      (state_q == ST_RESET_PLL) |-> pll_rst_q);

   a_ready_clean: assert property (
      @(posedge clk) disable iff (!rst_n)
      ready_q |-> (sys_rst_q == '0));

   for (genvar k = 1; k < NUM_RST; k++) begin : g_order
      a_rel_order: assert property (
         @(posedge clk) disable iff (!rst_n)
         !sys_rst_q[k] |-> !sys_rst_q[k-1]);
   end

endmodule

// File: tb/tb_pll_rst_seq.sv
// tb_pll_rst_seq: directed scenarios with an output-change scoreboard.
// Expected output snapshots are queued by cycle; a monitor checks them.
module tb_pll_rst_seq;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       pll_locked;
   logic       soft_rst;
   logic       pll_rst;
   logic [2:0] sys_rst;
   logic       ready;
   logic [7:0] retry_cnt;

   int cyc    = 0;
   int checks = 0;
   int errors = 0;

   typedef struct {
      int         cyc;
      logic       p;
      logic [2:0] s;
      logic       r;
      logic [7:0] n;
   } exp_t;

   exp_t q[$];

   pll_rst_seq #(
      .PLL_RST_CYCLES(4),
      .LOCK_FILT(8),
      .LOCK_TIMEOUT(32),
      .RELEASE_GAP(2),
      .NUM_RST(3)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .pll_locked(pll_locked),
      .soft_rst(soft_rst),
      .pll_rst(pll_rst),
      .sys_rst(sys_rst),
      .ready(ready),
      .retry_cnt(retry_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic push_exp(
      input int c, input logic p, input logic [2:0] s,
      input logic r, input logic [7:0] n);
      exp_t e;
      e.cyc = c; e.p = p; e.s = s; e.r = r; e.n = n;
      q.push_back(e);
   endtask

   task automatic at(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   // monitor: samples after every falling clock edge and reset assertion
   initial begin
      logic [12:0] cur;
      logic [12:0] last;
      logic [12:0] want;
      exp_t e;
      last = 'x;
      #2;
      forever begin
         @(negedge clk or negedge rst_n);
         #1;
         cur = {pll_rst, sys_rst, ready, retry_cnt};
         while (q.size() > 0 && q[0].cyc < cyc) begin
            e = q.pop_front();
            checks++;
            errors++;
            $display("FAIL missed cyc=%0d now=%0d got %b/%b/%b/%0d",
                     e.cyc, cyc, pll_rst, sys_rst, ready, retry_cnt);
         end
         if (q.size() > 0 && q[0].cyc == cyc) begin
            e = q.pop_front();
            want = {e.p, e.s, e.r, e.n};
            checks++;
            if (cur !== want) begin
               errors++;
               $display("FAIL outputs cyc=%0d got pll_rst=%b sys_rst=%b ready=%b retry=%0d exp pll_rst=%b sys_rst=%b ready=%b retry=%0d",
                        cyc, pll_rst, sys_rst, ready, retry_cnt,
                        e.p, e.s, e.r, e.n);
            end
         end else if (cur !== last) begin
            checks++;
            errors++;
            $display("FAIL unexpected_change cyc=%0d got %b/%b/%b/%0d prev %b",
                     cyc, pll_rst, sys_rst, ready, retry_cnt, last);
         end
         last = cur;
      end
   end

   initial begin
      int b, c, d, e, tend;
      logic [7:0] rn;
      rst_n      = 1'b0;
      pll_locked = 1'b1;
      soft_rst   = 1'b0;

      // reset values while rst_n is low
      push_exp(1, 1'b1, 3'b111, 1'b0, 8'd0);

      // power-up with lock present
      b = 3;
      push_exp(b + 4,  1'b0, 3'b111, 1'b0, 8'd0);
      push_exp(b + 14, 1'b0, 3'b110, 1'b0, 8'd0);
      push_exp(b + 16, 1'b0, 3'b100, 1'b0, 8'd0);
      push_exp(b + 18, 1'b0, 3'b000, 1'b0, 8'd0);
      push_exp(b + 20, 1'b0, 3'b000, 1'b1, 8'd0);
      at(b);
      rst_n = 1'b1;

      // lock drops in RUN, returns later
      c = b + 25;
      d = c + 10;
      push_exp(c + 3,  1'b1, 3'b111, 1'b0, 8'd1);
      push_exp(c + 7,  1'b0, 3'b111, 1'b0, 8'd1);
      push_exp(d + 12, 1'b0, 3'b110, 1'b0, 8'd1);
      push_exp(d + 14, 1'b0, 3'b100, 1'b0, 8'd1);
      push_exp(d + 16, 1'b0, 3'b000, 1'b0, 8'd1);
      push_exp(d + 18, 1'b0, 3'b000, 1'b1, 8'd1);
      at(c);
      pll_locked = 1'b0;
      at(d);
      pll_locked = 1'b1;

      // soft restart, then a one-cycle lock glitch during FILTER
      e = d + 25;
      push_exp(e + 1,  1'b1, 3'b111, 1'b0, 8'd1);
      push_exp(e + 5,  1'b0, 3'b111, 1'b0, 8'd1);
      push_exp(e + 20, 1'b0, 3'b110, 1'b0, 8'd1);
      push_exp(e + 22, 1'b0, 3'b100, 1'b0, 8'd1);
      push_exp(e + 24, 1'b0, 3'b000, 1'b0, 8'd1);
      push_exp(e + 26, 1'b0, 3'b000, 1'b1, 8'd1);
      at(e);
      soft_rst = 1'b1;
      at(e + 1);
      soft_rst = 1'b0;
      at(e + 7);
      pll_locked = 1'b0;
      at(e + 8);
      pll_locked = 1'b1;

      // soft_rst in the same cycle locked_s falls: no retry increment
      c = e + 32;
      d = c + 10;
      push_exp(c + 3,  1'b1, 3'b111, 1'b0, 8'd1);
      push_exp(c + 7,  1'b0, 3'b111, 1'b0, 8'd1);
      push_exp(d + 12, 1'b0, 3'b110, 1'b0, 8'd1);
      push_exp(d + 14, 1'b0, 3'b100, 1'b0, 8'd1);
      push_exp(d + 16, 1'b0, 3'b000, 1'b0, 8'd1);
      push_exp(d + 18, 1'b0, 3'b000, 1'b1, 8'd1);
      at(c);
      pll_locked = 1'b0;
      at(c + 2);
      soft_rst = 1'b1;
      at(c + 3);
      soft_rst = 1'b0;
      at(d);
      pll_locked = 1'b1;

      // async reset mid-RELEASE while sys_rst is 100
      e = d + 25;
      push_exp(e + 1,  1'b1, 3'b111, 1'b0, 8'd1);
      push_exp(e + 5,  1'b0, 3'b111, 1'b0, 8'd1);
      push_exp(e + 15, 1'b0, 3'b110, 1'b0, 8'd1);
      push_exp(e + 17, 1'b0, 3'b100, 1'b0, 8'd1);
      push_exp(e + 17, 1'b1, 3'b111, 1'b0, 8'd0);
      at(e);
      soft_rst = 1'b1;
      at(e + 1);
      soft_rst = 1'b0;
      at(e + 17);
      #2;
      rst_n      = 1'b0;
      pll_locked = 1'b0;

      // lock held low after reset release
      b = e + 20;
      push_exp(b + 4, 1'b0, 3'b111, 1'b0, 8'd0);
`ifdef PLL_RST_SEQ_TIMEOUT_EN
      for (int n = 1; n <= 257; n++) begin
         rn = (n > 255) ? 8'd255 : 8'(n);
         push_exp(b + 36 * n,     1'b1, 3'b111, 1'b0, rn);
         push_exp(b + 36 * n + 4, 1'b0, 3'b111, 1'b0, rn);
      end
      tend = b + 36 * 257 + 10;
`else
      push_exp(b + 204, 1'b0, 3'b111, 1'b0, 8'd0);
      tend = b + 210;
`endif
      at(b);
      rst_n = 1'b1;
      at(tend);

      while (q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL pending cyc=%0d never checked", q[0].cyc);
         void'(q.pop_front());
      end

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
